fwd_hazard_unit: RTL and testbench

Parametrised forwarding and interlock unit for the 5-stage RISC-V pipeline. It replaces the purely combinational EX-stage forwarding control. It keeps its own EX/MEM/WB destination-tag pipeline and a latency counter for a fixed-latency multi-cycle unit (MDU). From these it generates per-source forwarding selects for EX, plus a single stall to IF/ID covering load-use, MDU RAW/WAW and MDU structural hazards.

---
 rtl/fwd_hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage forwarding selects plus a single IF/ID stall for
//   load-use, MDU RAW/WAW and MDU structural hazards; tracks its own
//   EX/MEM/WB destination tags and a fixed-latency MDU countdown.
// Latency: stall_o and fwd_sel_o are combinational from ID inputs and registered
//   state (0 cycles); all tags, the MDU counter and mdu_* outputs are registered.
// Backpressure: none accepted; stall_o holds PC and IF/ID and inserts an EX bubble.
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   id_*_i                  decoded ID-stage instruction (valid, sources, dest, kind)
//   stall_o                 hold IF/ID, bubble into EX
//   fwd_sel_o               per-source EX operand select (00 RF, 01 WB, 10 MEM, 11 MDU)
//   mdu_busy_o/done_o/rd_o  MDU countdown non-zero / result valid / destination
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_is_load_i,
  input  logic                      id_is_mdu_i,
  output logic                      stall_o,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic                      mdu_busy_o,
  output logic                      mdu_done_o,
  output logic [REG_AW-1:0]         mdu_rd_o
);

  localparam int CW = $clog2(MDU_LAT + 1);

  // EX tag
  logic                      r_ex_valid;
  logic [NUM_SRC*REG_AW-1:0] r_ex_rs;
  logic [NUM_SRC-1:0]        r_ex_rs_used;
  logic [REG_AW-1:0]         r_ex_rd;
  logic                      r_ex_regwrite;
  logic                      r_ex_is_load;
  logic                      r_ex_is_mdu;
  // MEM / WB tags
  logic [REG_AW-1:0]         r_mem_rd;
  logic                      r_mem_regwrite;
  logic [REG_AW-1:0]         r_wb_rd;
  logic                      r_wb_regwrite;
  // MDU tracking
  logic [CW-1:0]             r_cnt;
  logic [REG_AW-1:0]         r_mdu_rd;
  logic                      r_mdu_last;

  logic                      w_stall;
  logic                      w_issue;
  logic                      w_mdu_pend;
  logic                      w_ex_ld_live;
  logic                      w_mem_live;
  logic                      w_wb_live;
  logic                      w_ld_use;
  logic                      w_raw;
  logic                      w_waw;
  logic                      w_struct;
  logic [2*NUM_SRC-1:0]      w_fwd;

  assign w_issue      = id_valid_i && !w_stall;
  // cnt>=2 means the result is not yet visible even on the done cycle's forward path
  assign w_mdu_pend   = (r_cnt >= CW'(2));
  assign w_ex_ld_live = r_ex_valid && r_ex_is_load && r_ex_regwrite && (r_ex_rd != '0);
  assign w_mem_live   = r_mem_regwrite && (r_mem_rd != '0);
  assign w_wb_live    = r_wb_regwrite && (r_wb_rd != '0);

  // Source-match hazards against the load in EX and the in-flight MDU op.
  always_comb begin
    w_ld_use = 1'b0;
    w_raw    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used_i[i]) begin
        if (w_ex_ld_live && (id_rs_i[i*REG_AW +: REG_AW] == r_ex_rd))
          w_ld_use = 1'b1;
        if (w_mdu_pend && (r_mdu_rd != '0) && (id_rs_i[i*REG_AW +: REG_AW] == r_mdu_rd))
          w_raw = 1'b1;
      end
    end
  end

  assign w_waw    = w_mdu_pend && id_regwrite_i && (id_rd_i != '0) && (id_rd_i == r_mdu_rd);
  assign w_struct = w_mdu_pend && id_is_mdu_i;
  assign w_stall  = id_valid_i && (w_ld_use || w_raw || w_waw || w_struct);

  // Forwarding priority: MDU result (only the cycle after done), then MEM, then WB.
  always_comb begin
    w_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_ex_valid && r_ex_rs_used[i] && (r_ex_rs[i*REG_AW +: REG_AW] != '0)) begin
        if (r_mdu_last && (r_ex_rs[i*REG_AW +: REG_AW] == r_mdu_rd))
          w_fwd[2*i +: 2] = 2'b11;
        else if (w_mem_live && (r_mem_rd == r_ex_rs[i*REG_AW +: REG_AW]))
          w_fwd[2*i +: 2] = 2'b10;
        else if (w_wb_live && (r_wb_rd == r_ex_rs[i*REG_AW +: REG_AW]))
          w_fwd[2*i +: 2] = 2'b01;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs        <= '0;
      r_ex_rs_used   <= '0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_is_load   <= 1'b0;
      r_ex_is_mdu    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
      r_cnt          <= '0;
      r_mdu_rd       <= '0;
      r_mdu_last     <= 1'b0;
    end else begin
      if (w_issue) begin
        r_ex_valid    <= 1'b1;
        r_ex_rs       <= id_rs_i;
        r_ex_rs_used  <= id_rs_used_i;
        r_ex_rd       <= id_rd_i;
        r_ex_regwrite <= id_regwrite_i;
        r_ex_is_load  <= id_is_load_i;
        r_ex_is_mdu   <= id_is_mdu_i;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_rs_used  <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_is_load  <= 1'b0;
        r_ex_is_mdu   <= 1'b0;
      end
      // MDU ops write back through mdu_done_o, never through MEM/WB
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_valid && r_ex_regwrite && !r_ex_is_mdu;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      // Reload wins over decrement so an MDU op may issue on the done cycle
      if (w_issue && id_is_mdu_i) begin
        r_cnt    <= CW'(MDU_LAT);
        r_mdu_rd <= id_rd_i;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      r_mdu_last <= (r_cnt == CW'(1));
    end
  end

  assign stall_o    = w_stall;
  assign fwd_sel_o  = w_fwd;
  assign mdu_busy_o = (r_cnt != '0);
  assign mdu_done_o = (r_cnt == CW'(1));
  assign mdu_rd_o   = r_mdu_rd;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed per-cycle vectors for fwd_hazard_unit
//   (NUM_SRC=2, REG_AW=5, MDU_LAT=4) plus a hand-written reset-mid-MDU sequence.
// Each row is the ID-stage content for one cycle and the outputs expected in that cycle.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [9:0] id_rs_i;
  logic [1:0] id_rs_used_i;
  logic [4:0] id_rd_i;
  logic       id_regwrite_i;
  logic       id_is_load_i;
  logic       id_is_mdu_i;
  logic       stall_o;
  logic [3:0] fwd_sel_o;
  logic       mdu_busy_o;
  logic       mdu_done_o;
  logic [4:0] mdu_rd_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .MDU_LAT(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rs_used_i  (id_rs_used_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_is_load_i  (id_is_load_i),
    .id_is_mdu_i   (id_is_mdu_i),
    .stall_o       (stall_o),
    .fwd_sel_o     (fwd_sel_o),
    .mdu_busy_o    (mdu_busy_o),
    .mdu_done_o    (mdu_done_o),
    .mdu_rd_o      (mdu_rd_o)
  );

  typedef struct {
    string      nm;
    logic       v;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       md;
    logic       st;
    logic [3:0] fwd;
    logic       busy;
    logic       done;
    logic [4:0] mrd;
  } row_t;

  row_t vec[$];

  function automatic row_t mk(string nm, int v, int rs0, int rs1, int used, int rd,
                              int rw, int ld, int md, int st, int fwd,
                              int busy, int done, int mrd);
    row_t r;
    r.nm   = nm;
    r.v    = 1'(v);
    r.rs0  = 5'(rs0);
    r.rs1  = 5'(rs1);
    r.used = 2'(used);
    r.rd   = 5'(rd);
    r.rw   = 1'(rw);
    r.ld   = 1'(ld);
    r.md   = 1'(md);
    r.st   = 1'(st);
    r.fwd  = 4'(fwd);
    r.busy = 1'(busy);
    r.done = 1'(done);
    r.mrd  = 5'(mrd);
    return r;
  endfunction

  function automatic row_t bub(string nm, int fwd, int busy, int done, int mrd);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, fwd, busy, done, mrd);
  endfunction

  task automatic drive(input row_t r);
    id_valid_i    = r.v;
    id_rs_i       = {r.rs1, r.rs0};
    id_rs_used_i  = r.used;
    id_rd_i       = r.rd;
    id_regwrite_i = r.rw;
    id_is_load_i  = r.ld;
    id_is_mdu_i   = r.md;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_row(input row_t r);
    chk({r.nm, ".stall"}, 32'(stall_o),    32'(r.st));
    chk({r.nm, ".fwd"},   32'(fwd_sel_o),  32'(r.fwd));
    chk({r.nm, ".busy"},  32'(mdu_busy_o), 32'(r.busy));
    chk({r.nm, ".done"},  32'(mdu_done_o), 32'(r.done));
    chk({r.nm, ".mdurd"}, 32'(mdu_rd_o),   32'(r.mrd));
  endtask

  initial begin
    row_t idle;
    row_t mul8;
    row_t dep8;
    idle = bub("idle", 0, 0, 0, 0);
    mul8 = mk("rst_mul", 1, 1, 2, 3, 8, 1, 0, 1, 0, 0, 0, 0, 0);
    dep8 = mk("rst_dep", 1, 8, 1, 3, 9, 1, 0, 0, 0, 0, 0, 0, 0);

    //            name   v rs0 rs1 used rd rw ld md | st fwd busy done mrd
    // ALU chain: add x5,x1,x2; sub x6,x5,x5; or x7,x5,x6
    vec.push_back(mk("a0_add", 1, 1, 2, 3, 5, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    vec.push_back(mk("a1_sub", 1, 5, 5, 3, 6, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    vec.push_back(mk("a2_or",  1, 5, 6, 3, 7, 1, 0, 0, 0, 4'b1010, 0, 0, 0));
    vec.push_back(bub("a3_orEX", 4'b1001, 0, 0, 0));
    vec.push_back(bub("a4", 0, 0, 0, 0));
    vec.push_back(bub("a5", 0, 0, 0, 0));
    vec.push_back(bub("a6", 0, 0, 0, 0));
    // Load-use: lw x3,(x1); add x4,x3,x0
    vec.push_back(mk("b0_lw",    1, 1, 0, 1, 3, 1, 1, 0, 0, 4'b0000, 0, 0, 0));
    vec.push_back(mk("b1_use",   1, 3, 0, 3, 4, 1, 0, 0, 1, 4'b0000, 0, 0, 0));
    vec.push_back(mk("b2_held",  1, 3, 0, 3, 4, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    vec.push_back(bub("b3_addEX", 4'b0001, 0, 0, 0));
    vec.push_back(bub("b4", 0, 0, 0, 0));
    vec.push_back(bub("b5", 0, 0, 0, 0));
    vec.push_back(bub("b6", 0, 0, 0, 0));
    // MDU RAW: mul x8,x1,x2; add x9,x8,x1
    vec.push_back(mk("c0_mul",  1, 1, 2, 3, 8, 1, 0, 1, 0, 4'b0000, 0, 0, 0));
    vec.push_back(mk("c1_raw",  1, 8, 1, 3, 9, 1, 0, 0, 1, 4'b0000, 1, 0, 8));
    vec.push_back(mk("c2_raw",  1, 8, 1, 3, 9, 1, 0, 0, 1, 4'b0000, 1, 0, 8));
    vec.push_back(mk("c3_raw",  1, 8, 1, 3, 9, 1, 0, 0, 1, 4'b0000, 1, 0, 8));
    vec.push_back(mk("c4_done", 1, 8, 1, 3, 9, 1, 0, 0, 0, 4'b0000, 1, 1, 8));
    vec.push_back(bub("c5_mduFwd", 4'b0011, 0, 0, 8));
    vec.push_back(bub("c6", 0, 0, 0, 8));
    vec.push_back(bub("c7", 0, 0, 0, 8));
    vec.push_back(bub("c8", 0, 0, 0, 8));
    // MDU WAW: div x8,x3,x4; addi x8,x1
    vec.push_back(mk("d0_div",  1, 3, 4, 3, 8, 1, 0, 1, 0, 4'b0000, 0, 0, 8));
    vec.push_back(mk("d1_waw",  1, 1, 0, 1, 8, 1, 0, 0, 1, 4'b0000, 1, 0, 8));
    vec.push_back(mk("d2_waw",  1, 1, 0, 1, 8, 1, 0, 0, 1, 4'b0000, 1, 0, 8));
    vec.push_back(mk("d3_waw",  1, 1, 0, 1, 8, 1, 0, 0, 1, 4'b0000, 1, 0, 8));
    vec.push_back(mk("d4_done", 1, 1, 0, 1, 8, 1, 0, 0, 0, 4'b0000, 1, 1, 8));
    vec.push_back(bub("d5", 0, 0, 0, 8));
    vec.push_back(bub("d6", 0, 0, 0, 8));
    vec.push_back(bub("d7", 0, 0, 0, 8));
    vec.push_back(bub("d8", 0, 0, 0, 8));
    // Structural: div x8; add x10 (independent); mul x2,x5,x6 issues on the done cycle
    vec.push_back(mk("e0_div",    1, 3, 4, 3, 8, 1, 0, 1, 0, 4'b0000, 0, 0, 8));
    vec.push_back(mk("e1_indep",  1, 11, 12, 3, 10, 1, 0, 0, 0, 4'b0000, 1, 0, 8));
    vec.push_back(mk("e2_struct", 1, 5, 6, 3, 2, 1, 0, 1, 1, 4'b0000, 1, 0, 8));
    vec.push_back(mk("e3_struct", 1, 5, 6, 3, 2, 1, 0, 1, 1, 4'b0000, 1, 0, 8));
    vec.push_back(mk("e4_reload", 1, 5, 6, 3, 2, 1, 0, 1, 0, 4'b0000, 1, 1, 8));
    vec.push_back(bub("e5_newop", 0, 1, 0, 2));
    // invalid ID with hazard-looking fields must not stall
    vec.push_back(mk("e6_novld",  0, 2, 0, 1, 2, 1, 0, 1, 0, 4'b0000, 1, 0, 2));
    // rs1=x2 matches the MDU dest but is unused
    vec.push_back(mk("e7_unused", 1, 3, 2, 1, 10, 1, 0, 0, 0, 4'b0000, 1, 0, 2));
    vec.push_back(bub("e8_done", 0, 1, 1, 2));
    vec.push_back(bub("e9", 0, 0, 0, 2));
    vec.push_back(bub("e10", 0, 0, 0, 2));
    // x0: mul x0; add x1,x0,x0 (rs2 unused)
    vec.push_back(mk("f0_mulx0", 1, 1, 2, 3, 0, 1, 0, 1, 0, 4'b0000, 0, 0, 2));
    vec.push_back(mk("f1_x0",    1, 0, 0, 1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0));
    vec.push_back(bub("f2_x0EX", 0, 1, 0, 0));
    vec.push_back(bub("f3", 0, 1, 0, 0));
    vec.push_back(bub("f4_done", 0, 1, 1, 0));
    vec.push_back(bub("f5", 0, 0, 0, 0));

    // Reset state
    rst_i = 1'b1;
    drive(idle);
    repeat (2) @(negedge clk);
    #1;
    chk_row(bub("reset", 0, 0, 0, 0));
    rst_i = 1'b0;

    foreach (vec[i]) begin
      @(negedge clk);
      drive(vec[i]);
      #1;
      chk_row(vec[i]);
    end

    // Reset while the MDU countdown sits at 2 with a dependent op stalled in ID
    @(negedge clk);
    drive(mul8);
    #1;
    chk("rst_mul.busy", 32'(mdu_busy_o), 32'd0);
    @(negedge clk);
    drive(dep8);
    #1;
    chk("rst_dep_c4.stall", 32'(stall_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_dep_c2.stall", 32'(stall_o), 32'd1);
    chk("rst_dep_c2.busy",  32'(mdu_busy_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async.busy",  32'(mdu_busy_o), 32'd0);
    chk("rst_async.stall", 32'(stall_o),    32'd0);
    chk("rst_async.done",  32'(mdu_done_o), 32'd0);
    chk("rst_async.mdurd", 32'(mdu_rd_o),   32'd0);
    chk("rst_async.fwd",   32'(fwd_sel_o),  32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) drive(idle);
      #1;
      chk("post_rst.done", 32'(mdu_done_o), 32'd0);
      chk("post_rst.busy", 32'(mdu_busy_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
